// File: rtl/seq_detect_pkg.sv
// Shared definitions for the multi-context sequence detector.
// Holds the detector state encoding used by the core and the scheduler.
package seq_detect_pkg;

  localparam int DET_STATE_W = 2;

  typedef enum logic [DET_STATE_W-1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } det_state_e;

endpackage

// File: rtl/seq_detect_core.sv
// Combinational step function of the a -> b -> (a&b)* detector.
// The state is stored outside this block, one copy per requester, so
// this core only computes the next state and the match flag.
//
//   state | meaning
//   S0    | idle, waiting for a=1
//   S1    | saw a, waiting for b=1
//   S2    | saw a then b; each a&b=1 sample is a match
//   other | illegal encoding, recovers to S0 without a match
import seq_detect_pkg::*;

module seq_detect_core (
  input  logic [DET_STATE_W-1:0] state_in,
  input  logic                   a,
  input  logic                   b,
  output logic [DET_STATE_W-1:0] state_next,
  output logic                   y
);

  // next-state and match decode for one granted sample
  always_comb begin
    state_next = S0;
    y          = 1'b0;
    case (state_in)
      S0: state_next = a ? S1 : S0;
      S1: state_next = b ? S2 : S0;
      S2: begin
        if (a && b) begin
          state_next = S2;
          y          = 1'b1;
        end
      end
      default: state_next = S0;
    endcase
  end

endmodule

// File: rtl/seq_detect_sched.sv
// Round-robin scheduler that time-shares one sequence detector core
// between NREQ requesters, each with its own saved detector context.
// Optional per-requester match counters are built only when the macro
// SEQ_DETECT_SCHED_CNT_EN is defined; otherwise cnt_out is tied to 0.
import seq_detect_pkg::*;

module seq_detect_sched #(
  parameter int NREQ  = 2,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_a,
  input  logic [NREQ-1:0]         req_b,
  input  logic [NREQ-1:0]         req_clr,
  output logic [NREQ-1:0]         req_ready,
  output logic                    match_valid,
  output logic [$clog2(NREQ)-1:0] match_id,
  input  logic [$clog2(NREQ)-1:0] cnt_sel,
  output logic [CNT_W-1:0]        cnt_out
);

  localparam int IDW = $clog2(NREQ);

  logic [DET_STATE_W-1:0] ctx [NREQ];
  logic [IDW-1:0]         rr_ptr;
  logic                   grant_valid;
  logic [IDW-1:0]         grant_idx;
  logic [IDW-1:0]         cand;
  logic                   step;
  logic                   hit;
  logic [DET_STATE_W-1:0] state_next;
  logic                   y;

  // pick the first valid requester at or after rr_ptr; scanning the
  // offsets downward lets the smallest offset win the final assignment
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IDW'((int'(rr_ptr) + k) % NREQ);
      if (req_valid[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // one-hot ready; a sample offered during reset is never consumed
  always_comb begin
    req_ready = '0;
    if (grant_valid && !reset) req_ready[grant_idx] = 1'b1;
  end

  assign step = grant_valid && !reset;
  // a clear on the granted requester swallows the sample without a match
  assign hit  = step && y && !req_clr[grant_idx];

  seq_detect_core u_core (
    .state_in   (ctx[grant_idx]),
    .a          (req_a[grant_idx]),
    .b          (req_b[grant_idx]),
    .state_next (state_next),
    .y          (y)
  );

  // context save, round-robin pointer and registered match pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) ctx[i] <= S0;
      rr_ptr      <= '0;
      match_valid <= 1'b0;
      match_id    <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_clr[i])                           ctx[i] <= S0;
        else if (step && (grant_idx == IDW'(i)))  ctx[i] <= state_next;
      end
      if (step) begin
        rr_ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
      end
      match_valid <= hit;
      if (hit) match_id <= grant_idx;
    end
  end

`ifdef SEQ_DETECT_SCHED_CNT_EN
  logic [CNT_W-1:0] cnt [NREQ];

  // saturating per-requester match counters, clear has priority
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_clr[i]) begin
          cnt[i] <= '0;
        end else if (hit && (grant_idx == IDW'(i)) && (cnt[i] != '1)) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // counter readback; out-of-range selects read as zero
  always_comb begin
    cnt_out = '0;
    if (int'(cnt_sel) < NREQ) cnt_out = cnt[cnt_sel];
  end
`else
  logic unused_cnt_sel;
  assign unused_cnt_sel = ^cnt_sel;

  // counters not built: readback is constantly zero
  always_comb begin
    cnt_out = '0;
  end
`endif

endmodule

// File: tb/tb_seq_detect_sched.sv
// Directed bench for seq_detect_sched (NREQ=2, CNT_W=8). The driver
// pushes the expected match response of every cycle into a queue; the
// monitor pops one entry after each rising edge and compares it.
// Counter expectations follow SEQ_DETECT_SCHED_CNT_EN.
module tb_seq_detect_sched;

  localparam int NREQ  = 2;
  localparam int CNT_W = 8;

  typedef struct {
    logic m;
    logic id;
    logic rst;
  } exp_t;

  logic             clk;
  logic             reset;
  logic [NREQ-1:0]  req_valid, req_a, req_b, req_clr, req_ready;
  logic             match_valid;
  logic             match_id;
  logic             cnt_sel;
  logic [CNT_W-1:0] cnt_out;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  seq_detect_sched #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_clr     (req_clr),
    .req_ready   (req_ready),
    .match_valid (match_valid),
    .match_id    (match_id),
    .cnt_sel     (cnt_sel),
    .cnt_out     (cnt_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int cexp(input int v);
`ifdef SEQ_DETECT_SCHED_CNT_EN
    return v;
`else
    return 0;
`endif
  endfunction

  // one cycle of stimulus: drive at the falling edge, check ready, queue response
  task automatic step(input logic [1:0] v, input logic [1:0] a, input logic [1:0] b,
                      input logic [1:0] clr, input logic rst, input logic [1:0] exp_rdy,
                      input logic exp_m, input logic exp_id);
    exp_t e;
    @(negedge clk);
    req_valid = v;
    req_a     = a;
    req_b     = b;
    req_clr   = clr;
    reset     = rst;
    #1;
    n_cmp++;
    if (req_ready !== exp_rdy) begin
      n_err++;
      $display("FAIL ready t=%0t got=%b want=%b", $time, req_ready, exp_rdy);
    end
    e.m = exp_m; e.id = exp_id; e.rst = rst;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic check_cnt(input logic sel, input int want, input string name);
    cnt_sel = sel;
    #1;
    n_cmp++;
    if (int'(cnt_out) !== want) begin
      n_err++;
      $display("FAIL %s cnt_out got=%0d want=%0d", name, cnt_out, want);
    end
  endtask

  // monitor: compare match outputs against the queued expectation
  initial begin : monitor
    exp_t e;
    logic last_id;
    last_id = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.rst)    last_id = 1'b0;
        else if (e.m) last_id = e.id;
        n_cmp++;
        if (match_valid !== e.m) begin
          n_err++;
          $display("FAIL match_valid t=%0t got=%b want=%b", $time, match_valid, e.m);
        end
        n_cmp++;
        if (match_id !== last_id) begin
          n_err++;
          $display("FAIL match_id t=%0t got=%b want=%b", $time, match_id, last_id);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : driver
    reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_clr = '0; cnt_sel = 1'b0;

    // reset, including a sample that must be ignored
    step(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0);
    step(2'b11, 2'b11, 2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0);
    idle();
    check_cnt(1'b0, 0, "reset_cnt0");

    // req0 alone: (1,0),(0,1),(1,1),(1,1) -> matches on the last two
    step(2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0);
    step(2'b01, 2'b00, 2'b01, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0);
    step(2'b01, 2'b01, 2'b01, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0);
    step(2'b01, 2'b01, 2'b01, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0);
    idle();
    check_cnt(1'b0, cexp(2), "single_cnt0");
    step(2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0);
    idle();
    check_cnt(1'b0, 0, "clr_cnt0");

    // both valid: rr_ptr=1 so req1 goes first; held samples for the waiting side
    step(2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0);
    step(2'b11, 2'b01, 2'b10, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0);
    step(2'b11, 2'b01, 2'b11, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0);
    step(2'b11, 2'b11, 2'b11, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0);
    step(2'b11, 2'b11, 2'b11, 2'b00, 1'b0, 2'b10, 1'b1, 1'b1);
    step(2'b11, 2'b01, 2'b01, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0);
    step(2'b11, 2'b01, 2'b01, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0);
    step(2'b01, 2'b01, 2'b01, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0);
    idle();
    check_cnt(1'b0, cexp(2), "rr_cnt0");
    check_cnt(1'b1, cexp(1), "rr_cnt1");

    // req1 to S2, then clear coinciding with a granted (1,1)
    step(2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0);
    step(2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0);
    step(2'b10, 2'b10, 2'b10, 2'b10, 1'b0, 2'b10, 1'b0, 1'b0);
    idle();
    check_cnt(1'b1, 0, "clr_grant_cnt1");
    step(2'b10, 2'b10, 2'b10, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0);
    step(2'b10, 2'b10, 2'b10, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0);

    // reset aborts a partial detection on req0
    step(2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0);
    step(2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0);
    step(2'b01, 2'b01, 2'b01, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0);
    step(2'b01, 2'b01, 2'b01, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0);
    step(2'b01, 2'b01, 2'b01, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0);
    idle();
    check_cnt(1'b0, 0, "reset_mid_cnt0");

    // req0 now in S2: 260 matches, counter saturates at 255
    for (int i = 0; i < 255; i++)
      step(2'b01, 2'b01, 2'b01, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0);
    idle();
    check_cnt(1'b0, cexp(255), "sat_reach");
    for (int i = 0; i < 5; i++)
      step(2'b01, 2'b01, 2'b01, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0);
    idle();
    check_cnt(1'b0, cexp(255), "sat_hold");
    check_cnt(1'b1, 0, "sat_cnt1");

    idle();
    @(posedge clk);
    #3;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain queue left=%0d want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
